// File: rtl/mont_const_streamer_pkg.sv
// Shared definitions for the Montgomery-constant generator: default sizes,
// controller state encoding and the stream select encodings.
package mont_pkg;
  localparam int MONT_DATA_WIDTH  = 32;
  localparam int MONT_DATA_LENGTH = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic SEL_R = 1'b0;
  localparam logic SEL_T = 1'b1;
endpackage

// File: rtl/mont_const_streamer_if.sv
// Word-serial valid/ready stream carrying the r and t constants to the operand RAMs.
interface mont_const_streamer_if
  import mont_pkg::*;
#(
  parameter int DATA_WIDTH = MONT_DATA_WIDTH
) ();
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sel;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (output out_data, output out_sel, output out_last, output out_valid,
                  input  out_ready);
  modport slave  (input  out_data, input  out_sel, input  out_last, input  out_valid,
                  output out_ready);
endinterface

// File: rtl/mont_const_streamer_mod_dbl_step.sv
// Combinational modular doubling: acc_next = 2*acc mod n by a single conditional subtract.
module mod_dbl_step #(
  parameter int L = 32
) (
  input  logic [L:0]   acc,
  input  logic [L-1:0] n,
  output logic [L:0]   acc_next
);
  logic [L+1:0] dbl;
  logic [L+1:0] diff;

  always_comb begin
    dbl      = {acc, 1'b0};
    diff     = dbl - {2'b00, n};
    acc_next = (dbl >= {2'b00, n}) ? diff[L:0] : dbl[L:0];
  end
endmodule

// File: rtl/mont_const_streamer.sv
// Computes n0p, r = 2^L mod n and t = 2^2L mod n, then streams r and t LSW first.
// Optional MONT_CONST_ODD_CHECK_EN rejects even/zero moduli with err instead of streaming.
module mont_const_streamer
  import mont_pkg::*;
#(
  parameter int DATA_WIDTH  = MONT_DATA_WIDTH,
  parameter int DATA_LENGTH = MONT_DATA_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] n,
  output logic [DATA_WIDTH-1:0]  n0p,
  output logic                   n0p_valid,
  mont_const_streamer_if.master  strm,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam int NWORDS = DATA_LENGTH / DATA_WIDTH;
  localparam int CW     = $clog2(2 * DATA_LENGTH);
  localparam int WW     = (NWORDS > 1) ? $clog2(2 * NWORDS) : 1;

  state_t                   state_q, state_d;
  logic [DATA_LENGTH:0]     acc_q, acc_nx;
  logic [DATA_LENGTH-1:0]   n_q, r_q;
  logic [2*DATA_LENGTH-1:0] sh_q;
  logic [CW-1:0]            cnt_q;
  logic [WW-1:0]            widx_q;
  logic [DATA_WIDTH-1:0]    y_q, ym_q, prod;
  logic                     calc_end, last_word, xfer, bad_n, vld;

  mod_dbl_step #(.L(DATA_LENGTH)) u_dbl (
    .acc      (acc_q),
    .n        (n_q),
    .acc_next (acc_nx)
  );

`ifdef MONT_CONST_ODD_CHECK_EN
  logic err_q;
  assign bad_n = ~n[0];
  always_ff @(posedge clk) begin
    if (rst)                         err_q <= 1'b0;
    else if (state_q == IDLE && start) err_q <= bad_n;
  end
  assign err = err_q;
`else
  assign bad_n = 1'b0;
  assign err   = 1'b0;
`endif

  assign calc_end  = (state_q == CALC) && (cnt_q == CW'(2 * DATA_LENGTH - 1));
  assign last_word = (widx_q == WW'(2 * NWORDS - 1));
  assign xfer      = vld && strm.out_ready;
  assign prod      = n_q[DATA_WIDTH-1:0] * y_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = bad_n ? DONE : CALC;
      CALC:   if (calc_end) state_d = STREAM;
      STREAM: if (xfer && last_word) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    vld  = (state_q == STREAM);
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign strm.out_valid = vld;
  assign strm.out_data  = sh_q[DATA_WIDTH-1:0];
  assign strm.out_sel   = (widx_q >= WW'(NWORDS)) ? SEL_T : SEL_R;
  assign strm.out_last  = last_word;

  // Datapath: doubling chain and n0p iteration share the CALC window; the
  // n0p mask walks off the top after W-1 steps so later cycles leave y alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      n_q       <= '0;
      r_q       <= '0;
      sh_q      <= '0;
      cnt_q     <= '0;
      widx_q    <= '0;
      y_q       <= '0;
      ym_q      <= '0;
      n0p       <= '0;
      n0p_valid <= 1'b0;
    end else if (state_q == IDLE) begin
      if (start) begin
        n_q       <= n;
        acc_q     <= (DATA_LENGTH+1)'(1);
        cnt_q     <= '0;
        widx_q    <= '0;
        y_q       <= DATA_WIDTH'(1);
        ym_q      <= DATA_WIDTH'(2);
        n0p_valid <= 1'b0;
      end
    end else if (state_q == CALC) begin
      acc_q <= acc_nx;
      cnt_q <= cnt_q + 1'b1;
      y_q   <= y_q | (prod & ym_q);
      ym_q  <= ym_q << 1;
      if (cnt_q == CW'(DATA_LENGTH - 1)) r_q <= acc_nx[DATA_LENGTH-1:0];
      if (calc_end) begin
        sh_q      <= {acc_nx[DATA_LENGTH-1:0], r_q};
        n0p       <= ~y_q + 1'b1;
        n0p_valid <= 1'b1;
      end
    end else if (state_q == STREAM) begin
      if (xfer) begin
        sh_q   <= sh_q >> DATA_WIDTH;
        widx_q <= widx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mont_const_streamer.sv
// Directed bench: small 8/32 instance for timing, backpressure, reset and start
// handling, plus a 32/1024 instance checked against a wide-arithmetic reference.
module tb_mont_const_streamer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Small instance: DATA_WIDTH=8, DATA_LENGTH=32
  logic        a_start, a_ready, a_n0p_valid, a_busy, a_done, a_err;
  logic [31:0] a_n;
  logic [7:0]  a_n0p;
  mont_const_streamer_if #(.DATA_WIDTH(8)) a_if ();
  assign a_if.out_ready = a_ready;

  mont_const_streamer #(.DATA_WIDTH(8), .DATA_LENGTH(32)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .n(a_n), .n0p(a_n0p), .n0p_valid(a_n0p_valid),
    .strm(a_if.master), .busy(a_busy), .done(a_done), .err(a_err)
  );

  // Default-size instance: DATA_WIDTH=32, DATA_LENGTH=1024
  logic          b_start, b_ready, b_n0p_valid, b_busy, b_done, b_err;
  logic [1023:0] b_n;
  logic [31:0]   b_n0p;
  mont_const_streamer_if #(.DATA_WIDTH(32)) b_if ();
  assign b_if.out_ready = b_ready;

  mont_const_streamer #(.DATA_WIDTH(32), .DATA_LENGTH(1024)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .n(b_n), .n0p(b_n0p), .n0p_valid(b_n0p_valid),
    .strm(b_if.master), .busy(b_busy), .done(b_done), .err(b_err)
  );

  task automatic check_zero_a(input string tag);
    check(tag, {a_n0p, a_n0p_valid, a_if.out_data, a_if.out_sel, a_if.out_last,
                a_if.out_valid, a_busy, a_done, a_err}, 64'h0);
  endtask

  // ew holds the eight expected stream words, word k at bits [8k+7:8k].
  task automatic run_a(input logic [31:0] nv, input logic [63:0] ew, input logic [7:0] en0p,
                       input bit bp, input bit poke);
    int cyc;
    int k;
    int ph;
    logic [7:0] w;
    @(negedge clk);
    a_n = nv; a_start = 1'b1; a_ready = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    cyc = 1;
    check("calc_busy", a_busy, 1);
    check("calc_n0pv", a_n0p_valid, 0);
    while (!a_if.out_valid && cyc < 200) begin
      if (poke && cyc == 10) begin a_start = 1'b1; a_n = 32'hFFFF_FFFF; end
      else a_start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    a_start = 1'b0;
    check("latency", cyc, 65);
    check("n0p", a_n0p, en0p);
    check("n0p_valid", a_n0p_valid, 1);
    k = 0; ph = 0; cyc = 0;
    while (k < 8 && cyc < 100) begin
      a_ready = bp ? (ph % 3 == 0) : 1'b1;
      ph++;
      a_start = poke && (k == 3);
      check("stream_vld", a_if.out_valid, 1);
      if (a_ready) begin
        w = ew[8*k +: 8];
        check($sformatf("w%0d_data", k), a_if.out_data, w);
        check($sformatf("w%0d_sel", k), a_if.out_sel, (k >= 4));
        check($sformatf("w%0d_last", k), a_if.out_last, (k == 7));
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    a_ready = 1'b1;
    check("stream_count", k, 8);
    check("done_vld", a_if.out_valid, 0);
    check("done_pulse", a_done, 1);
    a_start = poke;
    @(negedge clk);
    a_start = 1'b0;
    check("idle_busy", a_busy, 0);
    check("idle_done", a_done, 0);
  endtask

  task automatic run_b();
    logic [2047:0] big_n, r_ref, t_ref;
    logic [31:0]   pr, ew;
    int cyc;
    int k;
    for (int i = 0; i < 32; i++) b_n[32*i +: 32] = $urandom;
    b_n[0] = 1'b1;
    b_n[1023] = 1'b1;
    big_n = {1024'h0, b_n};
    r_ref = (2048'h1 << 1024) % big_n;
    t_ref = (r_ref * r_ref) % big_n;
    @(negedge clk);
    b_start = 1'b1; b_ready = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 1;
    while (!b_if.out_valid && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check("b_latency", cyc, 2049);
    check("b_n0p_valid", b_n0p_valid, 1);
    pr = b_n[31:0] * b_n0p;
    check("b_n_n0p", pr, 32'hFFFF_FFFF);
    k = 0; cyc = 0;
    while (k < 64 && cyc < 200) begin
      if (b_if.out_valid) begin
        ew = (k < 32) ? r_ref[32*k +: 32] : t_ref[32*(k-32) +: 32];
        check($sformatf("b_w%0d", k), b_if.out_data, ew);
        check($sformatf("b_w%0d_sel", k), b_if.out_sel, (k >= 32));
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    check("b_count", k, 64);
    check("b_done", b_done, 1);
    check("b_err", b_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst = 1'b1;
    a_start = 1'b0; a_ready = 1'b1; a_n = '0;
    b_start = 1'b0; b_ready = 1'b1; b_n = '0;
    repeat (2) @(negedge clk);
    check_zero_a("reset_a");
    check("reset_b", {b_if.out_valid, b_busy, b_done, b_n0p_valid, b_n0p}, 0);
    rst = 1'b0;

    run_a(32'h0000_00F1, 64'h0000_00E1_0000_000F, 8'hEF, 1'b0, 1'b0);
    run_a(32'hFFFF_FFFF, 64'h0000_0001_0000_0001, 8'h01, 1'b0, 1'b0);
    run_a(32'h0000_00F1, 64'h0000_00E1_0000_000F, 8'hEF, 1'b1, 1'b0);

    // Abort mid-CALC
    @(negedge clk);
    a_n = 32'h0000_00F1; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_a("rst_calc");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_calc_quiet", {a_busy, a_done}, 0);

    // Abort mid-STREAM after two words
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    cyc = 0;
    while (!a_if.out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_stream_reached", a_if.out_valid, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero_a("rst_stream");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stream_quiet", {a_busy, a_done}, 0);

    run_a(32'h0000_00F1, 64'h0000_00E1_0000_000F, 8'hEF, 1'b0, 1'b0);
    run_a(32'h0000_00F1, 64'h0000_00E1_0000_000F, 8'hEF, 1'b0, 1'b1);

`ifdef MONT_CONST_ODD_CHECK_EN
    @(negedge clk);
    a_n = 32'h0000_0100; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    check("odd_err", a_err, 1);
    check("odd_done", a_done, 1);
    check("odd_vld", a_if.out_valid, 0);
    check("odd_n0pv", a_n0p_valid, 0);
    @(negedge clk);
    check("odd_idle", {a_busy, a_done, a_if.out_valid}, 0);
    check("odd_err_hold", a_err, 1);
`else
    check("err_tied", a_err, 0);
`endif

    run_b();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
